// File: rtl/thresholding_axilite_loader_if.sv
// Signal bundle between the threshold loader and its environment: the
// threshold source stream and the AXI4-Lite write channels. The read-back
// channels exist only when THRESHOLDING_LOADER_VERIFY_EN is defined.
interface thresholding_axilite_loader_if #(
  parameter int unsigned K         = 16,
  parameter int unsigned ADDR_BITS = 9
);
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [K-1:0]         s_axis_tdata;

  logic                 m_axilite_AWVALID;
  logic                 m_axilite_AWREADY;
  logic [ADDR_BITS-1:0] m_axilite_AWADDR;
  logic                 m_axilite_WVALID;
  logic                 m_axilite_WREADY;
  logic [31:0]          m_axilite_WDATA;
  logic [3:0]           m_axilite_WSTRB;
  logic                 m_axilite_BVALID;
  logic                 m_axilite_BREADY;
  logic [1:0]           m_axilite_BRESP;

`ifdef THRESHOLDING_LOADER_VERIFY_EN
  logic                 m_axilite_ARVALID;
  logic                 m_axilite_ARREADY;
  logic [ADDR_BITS-1:0] m_axilite_ARADDR;
  logic                 m_axilite_RVALID;
  logic                 m_axilite_RREADY;
  logic [31:0]          m_axilite_RDATA;
  logic [1:0]           m_axilite_RRESP;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, output s_axis_tready,
    output m_axilite_AWVALID, m_axilite_AWADDR, input m_axilite_AWREADY,
    output m_axilite_WVALID, m_axilite_WDATA, m_axilite_WSTRB, input m_axilite_WREADY,
    input  m_axilite_BVALID, m_axilite_BRESP, output m_axilite_BREADY,
    output m_axilite_ARVALID, m_axilite_ARADDR, input m_axilite_ARREADY,
    input  m_axilite_RVALID, m_axilite_RDATA, m_axilite_RRESP, output m_axilite_RREADY
  );
  modport slave (
    output s_axis_tvalid, s_axis_tdata, input s_axis_tready,
    input  m_axilite_AWVALID, m_axilite_AWADDR, output m_axilite_AWREADY,
    input  m_axilite_WVALID, m_axilite_WDATA, m_axilite_WSTRB, output m_axilite_WREADY,
    output m_axilite_BVALID, m_axilite_BRESP, input m_axilite_BREADY,
    input  m_axilite_ARVALID, m_axilite_ARADDR, output m_axilite_ARREADY,
    output m_axilite_RVALID, m_axilite_RDATA, m_axilite_RRESP, input m_axilite_RREADY
  );
`else
  modport master (
    input  s_axis_tvalid, s_axis_tdata, output s_axis_tready,
    output m_axilite_AWVALID, m_axilite_AWADDR, input m_axilite_AWREADY,
    output m_axilite_WVALID, m_axilite_WDATA, m_axilite_WSTRB, input m_axilite_WREADY,
    input  m_axilite_BVALID, m_axilite_BRESP, output m_axilite_BREADY
  );
  modport slave (
    output s_axis_tvalid, s_axis_tdata, input s_axis_tready,
    input  m_axilite_AWVALID, m_axilite_AWADDR, output m_axilite_AWREADY,
    input  m_axilite_WVALID, m_axilite_WDATA, m_axilite_WSTRB, output m_axilite_WREADY,
    output m_axilite_BVALID, m_axilite_BRESP, input m_axilite_BREADY
  );
`endif
endinterface

// File: rtl/thresholding_axilite_loader.sv
// AXI4-Lite write initiator that streams thresholds (channel-major,
// index-minor) into the threshold memory of thresholding_axi, one single-beat
// write per threshold. Optional read-back verification of every write is
// enabled with THRESHOLDING_LOADER_VERIFY_EN.
module thresholding_axilite_loader #(
  parameter int unsigned N  = 4,
  parameter int unsigned C  = 6,
  parameter int unsigned PE = 3,
  parameter int unsigned K  = 16
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  thresholding_axilite_loader_if.master bus
);
  localparam int unsigned CB        = $clog2(C / PE);
  localparam int unsigned PB        = $clog2(PE);
  localparam int unsigned ADDR_BITS = CB + PB + N + 2;
  localparam int unsigned CW        = (C > 1) ? $clog2(C) : 1;
  localparam logic [N-1:0]  I_LAST  = N'(2**N - 2);
  localparam logic [CW-1:0] C_LAST  = CW'(C - 1);

`ifdef THRESHOLDING_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_B, READ, WAIT_R, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_B, DONE} state_e;
`endif

  state_e                state_q, state_d;
  logic [CW-1:0]         c_q, c_d;
  logic [N-1:0]          i_q, i_d;
  logic [ADDR_BITS-1:0]  awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef THRESHOLDING_LOADER_VERIFY_EN
  logic                  arvalid_q, arvalid_d;
`endif
  logic [ADDR_BITS-1:0]  addr_calc;
  logic                  advance;

  // Word address of threshold (c, i); the c%PE and c/PE fields collapse to
  // zero width naturally when PE=1 or C=PE.
  always_comb begin
    addr_calc = ADDR_BITS'(((32'(c_q) / PE) << (PB + N + 2))
                         | ((32'(c_q) % PE) << (N + 2))
                         | (32'(i_q) << 2));
  end

  // Next-state, counter advance and registered-output next values.
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    i_d       = i_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    advance   = 1'b0;
`ifdef THRESHOLDING_LOADER_VERIFY_EN
    arvalid_d = arvalid_q;
`endif
    unique case (state_q)
      IDLE: begin
        // done_q high means DONE was just left; a start in that cycle is dropped
        if (start && !done_q) begin
          c_d     = '0;
          i_d     = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.s_axis_tvalid) begin
          wdata_d   = 32'(signed'(bus.s_axis_tdata));
          awaddr_d  = addr_calc;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        awvalid_d = awvalid_q & ~bus.m_axilite_AWREADY;
        wvalid_d  = wvalid_q & ~bus.m_axilite_WREADY;
        if (!awvalid_d && !wvalid_d) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (bus.m_axilite_BVALID) begin
          if (bus.m_axilite_BRESP != 2'b00) err_d = 1'b1;
`ifdef THRESHOLDING_LOADER_VERIFY_EN
          arvalid_d = 1'b1;
          state_d   = READ;
`else
          advance   = 1'b1;
`endif
        end
      end
`ifdef THRESHOLDING_LOADER_VERIFY_EN
      READ: begin
        arvalid_d = arvalid_q & ~bus.m_axilite_ARREADY;
        if (!arvalid_d) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (bus.m_axilite_RVALID) begin
          if (bus.m_axilite_RRESP != 2'b00 || bus.m_axilite_RDATA != wdata_q) err_d = 1'b1;
          advance = 1'b1;
        end
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (c_q == C_LAST && i_q == I_LAST) begin
        state_d = DONE;
      end else begin
        state_d = FETCH;
        if (i_q == I_LAST) begin
          i_d = '0;
          c_d = c_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
    end
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      c_q       <= '0;
      i_q       <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef THRESHOLDING_LOADER_VERIFY_EN
      arvalid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      i_q       <= i_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef THRESHOLDING_LOADER_VERIFY_EN
      arvalid_q <= arvalid_d;
`endif
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign err                   = err_q;
  assign bus.s_axis_tready     = (state_q == FETCH);
  assign bus.m_axilite_AWVALID = awvalid_q;
  assign bus.m_axilite_AWADDR  = awaddr_q;
  assign bus.m_axilite_WVALID  = wvalid_q;
  assign bus.m_axilite_WDATA   = wdata_q;
  assign bus.m_axilite_WSTRB   = 4'hF;
  assign bus.m_axilite_BREADY  = (state_q == WAIT_B);
`ifdef THRESHOLDING_LOADER_VERIFY_EN
  assign bus.m_axilite_ARVALID = arvalid_q;
  assign bus.m_axilite_ARADDR  = awaddr_q;
  assign bus.m_axilite_RREADY  = (state_q == WAIT_R);
`endif
endmodule
